// File: rtl/serial_echo_proc.sv
// Buffered serial echo engine: stream transforms (pass/add/invert) through a FIFO,
// or line collection up to a terminator echoed back in reverse order.
module serial_echo_proc #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           BUF_DEPTH  = 16,
    parameter logic [DATA_WIDTH-1:0] ADD_VALUE  = DATA_WIDTH'(1),
    parameter logic [DATA_WIDTH-1:0] TERMINATOR = DATA_WIDTH'(8'h0D)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   mode,
    input  logic                         in_valid,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         out_ready,
    output logic [$clog2(BUF_DEPTH):0]   level,
    output logic                         overflow
);

    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
    localparam logic [CW-1:0] DEPTH_M1 = CW'(BUF_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_STREAM,
        ST_COLLECT,
        ST_FLUSH,
        ST_TERM
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              mode_q, mode_d;
    logic [DATA_WIDTH-1:0]   mem [BUF_DEPTH];
    logic [PW-1:0]           wr_ptr, wr_ptr_d;
    logic [PW-1:0]           rd_ptr, rd_ptr_d;
    logic [CW-1:0]           count, count_d;
    logic                    term_q, term_d;
    logic                    ovf_q, ovf_d;

    logic                    sample_pt;
    logic [1:0]              eff_mode;
    logic                    wr_en;
    logic [PW-1:0]           wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH-1:0]   xform;
    logic [CW-1:0]           count_m1;
    logic                    rdy;
    logic                    vld;
    logic [DATA_WIDTH-1:0]   dat;
    logic                    push;
    logic                    pop;

    // At a sample point the incoming mode applies in the same cycle, so the
    // first word after an idle mode switch is already handled in the new mode.
    assign sample_pt = ((state_q == ST_STREAM) || (state_q == ST_COLLECT)) && (count == '0);
    assign eff_mode  = sample_pt ? mode : mode_q;
    assign count_m1  = count - CW'(1);

    always_comb begin
        xform = in_data;
        case (eff_mode)
            2'd1:    xform = in_data + ADD_VALUE;
            2'd2:    xform = ~in_data;
            default: xform = in_data;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        count_d  = count;
        term_d   = term_q;
        ovf_d    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = wr_ptr;
        wr_data  = xform;
        rdy      = 1'b0;
        vld      = 1'b0;
        dat      = mem[rd_ptr];
        push     = 1'b0;
        pop      = 1'b0;

        case (state_q)
            ST_STREAM, ST_COLLECT: begin
                if (sample_pt) begin
                    mode_d = mode;
                end
                if (eff_mode == 2'd3) begin
                    state_d = ST_COLLECT;
                    rdy     = 1'b1;
                    if (in_valid) begin
                        if (in_data == TERMINATOR) begin
                            term_d  = 1'b1;
                            state_d = (count != '0) ? ST_FLUSH : ST_TERM;
                        end else begin
                            wr_en   = 1'b1;
                            wr_addr = count[PW-1:0];
                            wr_data = in_data;
                            count_d = count + CW'(1);
                            if (count == DEPTH_M1) begin
                                term_d  = 1'b0;
                                ovf_d   = 1'b1;
                                state_d = ST_FLUSH;
                            end
                        end
                    end
                end else begin
                    state_d = ST_STREAM;
                    rdy     = (count < DEPTH_C);
                    vld     = (count != '0);
                    push    = in_valid && rdy;
                    pop     = vld && out_ready;
                    if (push) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr + PW'(1);
                    end
                    if (pop) begin
                        rd_ptr_d = rd_ptr + PW'(1);
                    end
                    count_d = count + CW'(push) - CW'(pop);
                end
            end
            ST_FLUSH: begin
                vld = 1'b1;
                dat = mem[count_m1[PW-1:0]];
                if (out_ready) begin
                    count_d = count_m1;
                    if (count == CW'(1)) begin
                        state_d = term_q ? ST_TERM : ST_COLLECT;
                    end
                end
            end
            ST_TERM: begin
                vld = 1'b1;
                dat = TERMINATOR;
                if (out_ready) begin
                    term_d  = 1'b0;
                    state_d = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_STREAM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_STREAM;
            mode_q  <= 2'd0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            term_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            wr_ptr  <= wr_ptr_d;
            rd_ptr  <= rd_ptr_d;
            count   <= count_d;
            term_q  <= term_d;
            ovf_q   <= ovf_d;
        end
    end

    // Contents need no reset: count gates every read of the store.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign in_ready  = rst && rdy;
    assign out_valid = rst && vld;
    assign out_data  = rst ? dat : '0;
    assign level     = count;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_echo_proc.sv
// Directed self-checking bench for serial_echo_proc: stream modes, line echo,
// overflow, deferred mode change and asynchronous reset.
module tb_serial_echo_proc;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [4:0] level;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] push_q[$];
    logic [7:0] got_q[$];
    int         max_lvl;
    int         ovf_n;
    int         rdy_lo;
    int         cycles;
    int         pushed;

    serial_echo_proc #(
        .DATA_WIDTH(8),
        .BUF_DEPTH (16),
        .ADD_VALUE (8'h01),
        .TERMINATOR(8'h0D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .level    (level),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are observed there too, and a
    // word seen with out_valid && out_ready transfers on the following rising edge.
    // Called at posedge+1; returns at posedge+1 once the last transfers completed.
    task automatic drive(input int n_in, input int n_out, input int budget);
        int i;
        i = 0;
        cycles  = 0;
        max_lvl = 0;
        ovf_n   = 0;
        rdy_lo  = 0;
        got_q.delete();
        while ((i < n_in || got_q.size() < n_out) && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (overflow) ovf_n++;
            if (!in_ready) rdy_lo++;
            if (out_valid && out_ready) got_q.push_back(out_data);
            in_valid = (i < n_in);
            in_data  = (i < n_in) ? push_q[i] : 8'h00;
            if (in_valid && in_ready) i++;
        end
        pushed = i;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        mode      = 2'd0;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++;
        if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        n_checks++;
        if (level !== 5'd0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL release_idle: got level %0d valid %b expected 0 0", level, out_valid);
        end
    endtask

    task automatic test_pass();
        mode      = 2'd0;
        out_ready = 1'b1;
        push_q.delete();
        for (int j = 0; j < 16; j++) push_q.push_back(8'(j));
        drive(16, 16, 100);
        n_checks++;
        if (got_q.size() != 16) begin n_fail++; $display("FAIL pass_count: got %0d expected 16", got_q.size()); end
        for (int j = 0; j < got_q.size() && j < 16; j++) begin
            n_checks++;
            if (got_q[j] !== 8'(j)) begin n_fail++; $display("FAIL pass_word%0d: got %h expected %h", j, got_q[j], 8'(j)); end
        end
        n_checks++;
        if (max_lvl != 1) begin n_fail++; $display("FAIL pass_max_level: got %0d expected 1", max_lvl); end
        n_checks++;
        if (ovf_n != 0) begin n_fail++; $display("FAIL pass_overflow: got %0d expected 0", ovf_n); end
        n_checks++;
        if (cycles != 17) begin n_fail++; $display("FAIL pass_throughput: got %0d cycles expected 17", cycles); end
    endtask

    task automatic test_add();
        mode = 2'd1;
        push_q.delete();
        push_q.push_back(8'h41);
        push_q.push_back(8'hFF);
        drive(2, 2, 50);
        n_checks++;
        if (got_q.size() != 2) begin n_fail++; $display("FAIL add_count: got %0d expected 2", got_q.size()); end
        else begin
            n_checks++;
            if (got_q[0] !== 8'h42) begin n_fail++; $display("FAIL add_word0: got %h expected 42", got_q[0]); end
            n_checks++;
            if (got_q[1] !== 8'h00) begin n_fail++; $display("FAIL add_wrap: got %h expected 00", got_q[1]); end
        end
    endtask

    task automatic test_invert();
        logic [7:0] e;
        mode      = 2'd2;
        out_ready = 1'b0;
        push_q.delete();
        for (int j = 0; j < 16; j++) push_q.push_back(8'h50 + 8'(j));
        drive(16, 0, 50);
        n_checks++;
        if (pushed != 16) begin n_fail++; $display("FAIL inv_fill: got %0d accepted expected 16", pushed); end
        n_checks++;
        if (level !== 5'd16) begin n_fail++; $display("FAIL inv_full_level: got %0d expected 16", level); end
        in_valid = 1'b1;
        in_data  = 8'h60;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL inv_full_ready: got %b expected 0", in_ready); end
            n_checks++;
            if (out_data !== 8'hAF || out_valid !== 1'b1) begin
                n_fail++; $display("FAIL inv_stall_hold: got %h/%b expected af/1", out_data, out_valid);
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(0, 16, 50);
        n_checks++;
        if (got_q.size() != 16) begin n_fail++; $display("FAIL inv_count: got %0d expected 16", got_q.size()); end
        for (int j = 0; j < got_q.size() && j < 16; j++) begin
            e = 8'h50 + 8'(j);
            e = ~e;
            n_checks++;
            if (got_q[j] !== e) begin n_fail++; $display("FAIL inv_word%0d: got %h expected %h", j, got_q[j], e); end
        end
        n_checks++;
        if (level !== 5'd0) begin n_fail++; $display("FAIL inv_drained: got %0d expected 0", level); end
    endtask

    task automatic test_line();
        logic [7:0] exp_w[4];
        exp_w = '{8'h43, 8'h42, 8'h41, 8'h0D};
        mode = 2'd3;
        push_q.delete();
        push_q.push_back(8'h41);
        push_q.push_back(8'h42);
        push_q.push_back(8'h43);
        push_q.push_back(8'h0D);
        drive(4, 4, 50);
        n_checks++;
        if (got_q.size() != 4) begin n_fail++; $display("FAIL line_count: got %0d expected 4", got_q.size()); end
        for (int j = 0; j < got_q.size() && j < 4; j++) begin
            n_checks++;
            if (got_q[j] !== exp_w[j]) begin n_fail++; $display("FAIL line_word%0d: got %h expected %h", j, got_q[j], exp_w[j]); end
        end
        n_checks++;
        if (rdy_lo != 4) begin n_fail++; $display("FAIL line_ready_low: got %0d cycles expected 4", rdy_lo); end
        n_checks++;
        if (max_lvl != 3) begin n_fail++; $display("FAIL line_max_level: got %0d expected 3", max_lvl); end
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL line_resume: got ready %b valid %b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_overflow();
        push_q.delete();
        for (int j = 0; j < 16; j++) push_q.push_back(8'h20 + 8'(j));
        drive(16, 16, 100);
        n_checks++;
        if (got_q.size() != 16) begin n_fail++; $display("FAIL ovf_count: got %0d expected 16", got_q.size()); end
        for (int j = 0; j < got_q.size() && j < 16; j++) begin
            n_checks++;
            if (got_q[j] !== 8'h2F - 8'(j)) begin
                n_fail++; $display("FAIL ovf_word%0d: got %h expected %h", j, got_q[j], 8'h2F - 8'(j));
            end
        end
        n_checks++;
        if (ovf_n != 1) begin n_fail++; $display("FAIL ovf_pulses: got %0d expected 1", ovf_n); end
        n_checks++;
        if (rdy_lo != 16) begin n_fail++; $display("FAIL ovf_ready_low: got %0d expected 16", rdy_lo); end
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || level !== 5'd0) begin
            n_fail++; $display("FAIL ovf_no_term: got valid %b ready %b level %0d expected 0 1 0", out_valid, in_ready, level);
        end
        push_q.delete();
        push_q.push_back(8'h0D);
        drive(1, 1, 20);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'h0D) begin
            n_fail++; $display("FAIL lone_term: got %0d words first %h expected 1 word 0d", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
        end
        n_checks++;
        if (rdy_lo != 1 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL lone_term_ready: got low %0d now %b expected 1 1", rdy_lo, in_ready);
        end
    endtask

    task automatic test_mode_change();
        logic [7:0] exp_w[4];
        exp_w = '{8'h10, 8'h11, 8'h12, 8'h0D};
        mode      = 2'd0;
        out_ready = 1'b0;
        push_q.delete();
        push_q.push_back(8'h10);
        push_q.push_back(8'h11);
        push_q.push_back(8'h12);
        drive(3, 0, 20);
        n_checks++;
        if (level !== 5'd3) begin n_fail++; $display("FAIL mc_level3: got %0d expected 3", level); end
        mode = 2'd3;
        push_q.delete();
        push_q.push_back(8'h0D);
        drive(1, 0, 20);
        n_checks++;
        if (level !== 5'd4) begin n_fail++; $display("FAIL mc_deferred: got level %0d expected 4", level); end
        out_ready = 1'b1;
        drive(0, 4, 30);
        n_checks++;
        if (got_q.size() != 4) begin n_fail++; $display("FAIL mc_count: got %0d expected 4", got_q.size()); end
        for (int j = 0; j < got_q.size() && j < 4; j++) begin
            n_checks++;
            if (got_q[j] !== exp_w[j]) begin n_fail++; $display("FAIL mc_word%0d: got %h expected %h", j, got_q[j], exp_w[j]); end
        end
        push_q.delete();
        push_q.push_back(8'h58);
        push_q.push_back(8'h0D);
        drive(2, 2, 30);
        n_checks++;
        if (got_q.size() != 2 || got_q[0] !== 8'h58 || got_q[1] !== 8'h0D) begin
            n_fail++; $display("FAIL mc_line_after: got %0d words expected 58 0d", got_q.size());
        end
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b0;
        push_q.delete();
        push_q.push_back(8'h61);
        push_q.push_back(8'h62);
        push_q.push_back(8'h63);
        push_q.push_back(8'h0D);
        drive(4, 0, 20);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h63 || level !== 5'd3) begin
            n_fail++; $display("FAIL rf_flush: got %b/%h/%0d expected 1/63/3", out_valid, out_data, level);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            n_fail++; $display("FAIL rf_async: got valid %b level %0d expected 0 0", out_valid, level);
        end
        n_checks++;
        if (in_ready !== 1'b0 || out_data !== 8'h00 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL rf_outputs: got ready %b data %h ovf %b expected 0 00 0", in_ready, out_data, overflow);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || level !== 5'd0) begin
            n_fail++; $display("FAIL rf_release: got ready %b valid %b level %0d expected 1 0 0", in_ready, out_valid, level);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_add();
        test_invert();
        test_line();
        test_overflow();
        test_mode_change();
        test_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_echo_proc.md
# serial_echo_proc

Parametrised byte-stream echo processor for the serial demos. It sits between the receive byte stream and the transmit byte stream of the board's serial link and buffers received words in an internal store. In stream modes each word is transformed on entry: pass-through, add a constant, or bitwise invert. In line mode it collects words up to a terminator and echoes the line back in reverse order. It replaces the fixed single-byte increment-echo flow with a buffered, back-pressured, mode-selectable engine.

## Interface
Parameters:
- DATA_WIDTH, 8: width of every data word.
- BUF_DEPTH, 16: store depth in words; power of two, at least 2.
- ADD_VALUE, 1: constant added in mode 1; DATA_WIDTH bits.
- TERMINATOR, 8'h0D: line terminator for mode 3; DATA_WIDTH bits.

Ports:
- clk, input, 1: system clock; everything is on the rising edge.
- rst, input, 1: asynchronous, active-low reset. Assertion is immediate; release is synchronised externally.
- mode, input, 2: 0 = pass, 1 = add ADD_VALUE, 2 = invert, 3 = line-reverse. Sampled only at mode-sample points (see Operation).
- in_valid, input, 1: upstream word valid.
- in_data, input, DATA_WIDTH: upstream word.
- in_ready, output, 1: block accepts the word this cycle. A transfer occurs when in_valid && in_ready.
- out_valid, output, 1: downstream word valid.
- out_data, output, DATA_WIDTH: downstream word.
- out_ready, input, 1: downstream accepts. A transfer occurs when out_valid && out_ready.
- level, output, $clog2(BUF_DEPTH)+1: number of words currently stored.
- overflow, output, 1: one-cycle pulse when a line fills the store without a terminator.

## Operation
- Storage: a BUF_DEPTH-entry register array, a write pointer, a read pointer and a count (count drives level).
- Registered state: mode_q[1:0] and the FSM state.
- FSM states: STREAM, COLLECT, FLUSH, TERM. After reset: state = STREAM, mode_q = 0.
- Mode-sample points: STREAM with count == 0, and COLLECT with count == 0. At these points mode_q <= mode. State becomes COLLECT if mode == 3, otherwise STREAM. A mode change at any other time is ignored until the next sample point.
- STREAM (mode_q 0–2): the store acts as a circular FIFO.
  - in_ready = (count < BUF_DEPTH).
  - The written word is in_data, (in_data + ADD_VALUE) mod 2^DATA_WIDTH, or ~in_data, chosen by mode_q.
  - out_valid = (count != 0); out_data = mem[rd_ptr].
  - Pointers wrap modulo BUF_DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - When full, in_ready = 0, even if a pop happens in the same cycle.
- COLLECT (mode_q 3): in_ready = 1, out_valid = 0. Words are written from index 0 upward.
  - Accepted word equal to TERMINATOR: it is not stored, term_flag <= 1. Next state is FLUSH if count > 0, otherwise TERM.
  - Accepted word other than TERMINATOR: mem[count] <= word and count increments. If count reaches BUF_DEPTH: term_flag <= 0, overflow pulses in the following cycle, next state is FLUSH.
- FLUSH: in_ready = 0, out_valid = 1, out_data = mem[count-1].
  - Each out transfer decrements count.
  - When count reaches 0, next state is TERM if term_flag is set, otherwise COLLECT.
- TERM: in_ready = 0, out_valid = 1, out_data = TERMINATOR. On transfer, term_flag <= 0 and next state is COLLECT.
- Reset mid-operation: all stored words, pointers, term_flag and the pending overflow are discarded immediately.

## Timing
- While rst is low: in_ready = 0, out_valid = 0, overflow = 0, level = 0, out_data = 0.
- First cycle after release: in_ready = 1, the block is in STREAM with mode_q = 0.
- Stream latency: a word accepted on edge N presents on out_* from edge N (registered store write). out_valid is visible in cycle N+1. There is no combinational in-to-out bypass.
- out_data and out_valid stay stable while out_valid && !out_ready.
- Throughput in stream mode is one word per cycle in each direction, simultaneously.
- A line of L words plus terminator needs L+1 out transfers. in_ready is low from the cycle after the terminator is accepted until the cycle after TERM completes.
- level updates on the edge of each transfer.

## Test plan
- Mode 0, push 8'h00..8'h0F with out_ready = 1 -> identical sequence out, level never exceeds 1, no overflow.
- Mode 1 (ADD_VALUE = 1), push 8'h41, 8'hFF -> out 8'h42, 8'h00 (wrap-around).
- Mode 2, out_ready held 0, push 17 words -> in_ready drops after the 16th, level = 16. Then release out_ready -> 16 inverted words out in order, e.g. 8'h5A -> 8'hA5.
- Mode 3, push "ABC", 8'h0D -> out "CBA", 8'h0D. in_ready = 0 during the echo, then returns to 1.
- Mode 3, push 16 words with no terminator -> overflow pulses once, 16 words echo in reverse, no terminator sent, then COLLECT resumes. A lone 8'h0D -> a single 8'h0D echo.
- Change mode 0->3 while level = 3 -> mode takes effect only after level reaches 0. Assert rst mid-FLUSH -> out_valid = 0 and level = 0 immediately.
